// File: rtl/tick_gen_multi.sv
// Base tick divider feeding NCH programmable channel dividers.
// Channels count base ticks in parallel, or chain through each other when CASCADE=1.
module tick_gen_multi #(
  parameter int CLK_DIV = 500000,
  parameter int CNT_W   = 20,
  parameter int NCH     = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 100,
  parameter int CASCADE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [3:0]       ld_ch,
  input  logic [DIV_W-1:0] ld_val,
  output logic             tick_base,
  output logic [NCH-1:0]   tick
);

  localparam logic [CNT_W-1:0] BASE_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DEF_DIV);

  logic [CNT_W-1:0] base_q, base_d;
  logic             tb_q, tb_d;
  logic             bt;

  logic [DIV_W-1:0] div_q [NCH];
  logic [DIV_W-1:0] div_d [NCH];
  logic [DIV_W-1:0] cnt_q [NCH];
  logic [DIV_W-1:0] cnt_d [NCH];

  logic [NCH-1:0] adv;
  logic [NCH-1:0] term;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] tick_q, tick_d;
  logic           carry;

  assign bt = en && (base_q == BASE_LAST);

  always_comb begin
    base_d = base_q;
    if (clr) begin
      base_d = '0;
    end else if (bt) begin
      base_d = '0;
    end else if (en) begin
      base_d = base_q + 1'b1;
    end
    tb_d = bt && !clr;
  end

  // carry walks the terminal chain so cascading needs no i-1 index
  always_comb begin
    adv    = '0;
    term   = '0;
    hit    = '0;
    tick_d = '0;
    carry  = bt;
    for (int i = 0; i < NCH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      adv[i]   = (CASCADE != 0) ? carry : bt;
      term[i]  = adv[i] && (div_q[i] != '0)
                 && (cnt_q[i] == div_q[i] - 1'b1);
      carry    = term[i];
      hit[i]   = ld && (ld_ch == 4'(i));
      tick_d[i] = term[i] && !hit[i] && !clr;
      if (clr || hit[i] || term[i]) begin
        cnt_d[i] = '0;
      end else if (adv[i] && (div_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (hit[i]) begin
        div_d[i] = ld_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      tb_q   <= 1'b0;
      tick_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= DIV_RST;
        cnt_q[i] <= '0;
      end
    end else begin
      base_q <= base_d;
      tb_q   <= tb_d;
      tick_q <= tick_d;
      for (int i = 0; i < NCH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign tick_base = tb_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: parallel and cascaded instances share stimulus.
// Cycle-level expectations go through a scoreboard queue; scenarios add fixed timing checks.
module tb_tick_gen_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ld_ch = '0;
  logic [3:0] ld_val = '0;
  logic       tb0, tb1;
  logic [1:0] tk0, tk1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int mb;
  int md [2];
  int mc [2][2];

  logic [5:0] sb_q [$];

  always #5 clk = ~clk;

  tick_gen_multi #(
    .CLK_DIV(5), .CNT_W(3), .NCH(2),
    .DIV_W(4), .DEF_DIV(3), .CASCADE(0)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val),
    .tick_base(tb0), .tick(tk0)
  );

  tick_gen_multi #(
    .CLK_DIV(5), .CNT_W(3), .NCH(2),
    .DIV_W(4), .DEF_DIV(3), .CASCADE(1)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .ld(ld), .ld_ch(ld_ch), .ld_val(ld_val),
    .tick_base(tb1), .tick(tk1)
  );

  task automatic model_init();
    mb = 0;
    for (int i = 0; i < 2; i++) begin
      md[i] = 3;
      mc[0][i] = 0;
      mc[1][i] = 0;
    end
    sb_q.delete();
  endtask

  // expected outputs after the coming edge: {tb0, tk0[1:0], tb1, tk1[1:0]}
  task automatic model_edge(output logic [5:0] e);
    bit bt, adv, t, h;
    bit tm [2][2];
    e = '0;
    bt = en && (mb == 4);
    e[5] = bt && !clr;
    e[2] = bt && !clr;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c == 1 && i == 1) adv = bt && tm[1][0];
        else adv = bt;
        t = adv && (md[i] != 0) && (mc[c][i] == md[i] - 1);
        tm[c][i] = t;
        h = ld && (int'(ld_ch) == i);
        if (c == 0) e[3+i] = t && !h && !clr;
        else e[i] = t && !h && !clr;
        if (clr || h || t) mc[c][i] = 0;
        else if (adv && md[i] != 0) mc[c][i] = mc[c][i] + 1;
      end
    end
    for (int i = 0; i < 2; i++)
      if (ld && int'(ld_ch) == i) md[i] = int'(ld_val);
    if (clr) mb = 0;
    else if (en) mb = (mb == 4) ? 0 : mb + 1;
  endtask

  task automatic step(input string tag);
    logic [5:0] e, got, want;
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    want = sb_q.pop_front();
    got = {tb0, tk0, tb1, tk1};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    ld = 1'b0;
    ld_ch = '0;
    ld_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    model_init();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({tb0, tk0} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_u0 got=%b want=000", {tb0, tk0});
    end
    vectors++;
    if ({tb1, tk1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_u1 got=%b want=000", {tb1, tk1});
    end
  endtask

  task automatic test_free_run();
    logic [4:0] got, want;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 90; k++) begin
      step("free");
      want = {cyc % 5 == 0, cyc % 15 == 0, cyc % 15 == 0,
              cyc % 45 == 0, cyc % 15 == 0};
      got = {tb0, tk0[1], tk0[0], tk1[1], tk1[0]};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL free_timing cyc=%0d got=%b want=%b",
                 cyc, got, want);
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    en = 1'b1;
    ld = 1'b1; ld_ch = 4'd1; ld_val = 4'd0;
    step("dis_ld0");
    ld = 1'b0;
    for (int k = 0; k < 45; k++) begin
      step("dis_off");
      vectors++;
      if ({tk0[1], tk1[1]} !== 2'b00) begin
        miscompares++;
        $display("FAIL dis_off cyc=%0d got=%b want=00",
                 cyc, {tk0[1], tk1[1]});
      end
    end
    ld = 1'b1; ld_ch = 4'd1; ld_val = 4'd1;
    step("dis_ld1");
    ld = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step("dis_one");
      vectors++;
      if (tk0[1] !== tb0) begin
        miscompares++;
        $display("FAIL dis_one cyc=%0d got=%b want=%b",
                 cyc, tk0[1], tb0);
      end
    end
    ld = 1'b1; ld_ch = 4'd0; ld_val = 4'd0;
    step("dis_ch0");
    ld = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step("dis_casc");
      vectors++;
      if (tk1 !== 2'b00) begin
        miscompares++;
        $display("FAIL dis_casc cyc=%0d got=%b want=00", cyc, tk1);
      end
    end
  endtask

  task automatic test_load_collision();
    logic [1:0] want;
    do_reset();
    en = 1'b1;
    repeat (14) step("col_pre");
    ld = 1'b1; ld_ch = 4'd0; ld_val = 4'd2;
    step("col_ld");
    ld = 1'b0;
    vectors++;
    if ({tb0, tk0[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL col_win cyc=%0d got=%b want=10", cyc, {tb0, tk0[0]});
    end
    for (int k = 0; k < 30; k++) begin
      if (cyc + 1 == 20) begin
        ld = 1'b1; ld_ch = 4'd5; ld_val = 4'd7;
      end
      step("col_post");
      ld = 1'b0;
      want = {cyc % 15 == 0, cyc >= 25 && (cyc - 25) % 10 == 0};
      vectors++;
      if (tk0 !== want) begin
        miscompares++;
        $display("FAIL col_next cyc=%0d got=%b want=%b", cyc, tk0, want);
      end
    end
  endtask

  task automatic test_freeze_clr();
    do_reset();
    en = 1'b1;
    repeat (3) step("frz_pre");
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step("frz_hold");
      vectors++;
      if ({tb0, tb1} !== 2'b00) begin
        miscompares++;
        $display("FAIL frz_hold cyc=%0d got=%b want=00", cyc, {tb0, tb1});
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step("frz_resume");
      vectors++;
      if (tb0 !== (k == 2)) begin
        miscompares++;
        $display("FAIL frz_resume k=%0d got=%b want=%b", k, tb0, k == 2);
      end
    end
    repeat (4) step("clr_pre");
    clr = 1'b1;
    step("clr");
    clr = 1'b0;
    vectors++;
    if ({tb0, tb1, tk0, tk1} !== 6'b0) begin
      miscompares++;
      $display("FAIL clr_force got=%b want=000000", {tb0, tb1, tk0, tk1});
    end
    for (int k = 1; k <= 5; k++) begin
      step("clr_post");
      vectors++;
      if (tb0 !== (k == 5)) begin
        miscompares++;
        $display("FAIL clr_post k=%0d got=%b want=%b", k, tb0, k == 5);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    ld = 1'b1; ld_ch = 4'd0; ld_val = 4'd7;
    step("rm_ld0");
    ld = 1'b1; ld_ch = 4'd1; ld_val = 4'd1;
    step("rm_ld1");
    ld = 1'b0;
    repeat (8) step("rm_run");
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({tb0, tk0, tb1, tk1} !== 6'b0) begin
      miscompares++;
      $display("FAIL rm_async got=%b want=000000", {tb0, tk0, tb1, tk1});
    end
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step("rm_after");
      vectors++;
      if (tk0[0] !== (cyc % 15 == 0)) begin
        miscompares++;
        $display("FAIL rm_div cyc=%0d got=%b want=%b",
                 cyc, tk0[0], cyc % 15 == 0);
      end
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_free_run();
    test_disable();
    test_load_collision();
    test_freeze_clr();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
